multi_cycle_control_unit: RTL

Parametrised, sequential successor to the combinational opcode decoder. It registers the decoded control word once per instruction and steps a multi-cycle FSM through FETCH → DECODE → EXEC → MEM → WB, skipping phases the instruction does not need. It emits per-phase strobes to the datapath, handshakes with memory through `mem_req`/`mem_ready`, halts stickily on HLT and counts retired instructions. It sits between the instruction register and the datapath/memory interface.

---
 rtl/multi_cycle_control_unit.sv | 136 +++++++++++++
 1 files changed

// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle control unit: registers the decoded control word once per
// instruction and sequences FETCH/DECODE/EXEC/MEM/WB with memory handshake.
module multi_cycle_control_unit #(
    parameter int OPCODE_W = 4,
    parameter int CTRL_W   = 18,
    parameter logic [(2**OPCODE_W)*CTRL_W-1:0] DECODE_TABLE = {
        18'h02001, 18'h02000, 18'h02000, 18'h20500,
        18'h00000, 18'h06000, 18'h0A000, 18'h12042,
        18'h22242, 18'h22046, 18'h22044, 18'h22042,
        18'h01000, 18'h02020, 18'h22880, 18'h22080
    },
    parameter int RW_BIT  = 17,
    parameter int MW_BIT  = 16,
    parameter int MR_BIT  = 9,
    parameter int HLT_BIT = 0,
    parameter int CNT_W   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] Op_Code,
    input  logic                mem_ready,
    output logic [CTRL_W-1:0]   OUT,
    output logic                mem_req,
    output logic                mem_we,
    output logic                ir_we,
    output logic                pc_we,
    output logic                reg_we,
    output logic [2:0]          state,
    output logic                halted,
    output logic [CNT_W-1:0]    instr_count
);

    if (RW_BIT >= CTRL_W || MW_BIT >= CTRL_W || MR_BIT >= CTRL_W || HLT_BIT >= CTRL_W) begin : g_bad_bit
        $error("control bit index out of range of CTRL_W");
    end

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [CTRL_W-1:0]  out_q, out_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CTRL_W-1:0]  dec_entry;
    logic               retire;

    assign dec_entry = DECODE_TABLE[int'(Op_Code)*CTRL_W +: CTRL_W];

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        retire  = 1'b0;
        case (state_q)
            FETCH:  if (mem_ready) state_d = DECODE;
            DECODE: begin
                out_d   = dec_entry;
                state_d = dec_entry[HLT_BIT] ? HALT : EXEC;
            end
            EXEC: begin
                if (out_q[MR_BIT] || out_q[MW_BIT]) begin
                    state_d = MEM;
                end else if (out_q[RW_BIT]) begin
                    state_d = WB;
                end else begin
                    state_d = FETCH;
                    retire  = 1'b1;
                end
            end
            MEM: begin
                if (mem_ready) begin
                    if (out_q[RW_BIT]) begin
                        state_d = WB;
                    end else begin
                        state_d = FETCH;
                        retire  = 1'b1;
                    end
                end
            end
            WB: begin
                state_d = FETCH;
                retire  = 1'b1;
            end
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
        cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FETCH;
            out_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
        end
    end

    // Moore strobes; only the FETCH load strobes look at mem_ready.
    always_comb begin
        mem_req = 1'b0;
        mem_we  = 1'b0;
        ir_we   = 1'b0;
        pc_we   = 1'b0;
        reg_we  = 1'b0;
        halted  = 1'b0;
        case (state_q)
            FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
                pc_we   = mem_ready;
            end
            MEM: begin
                mem_req = 1'b1;
                mem_we  = out_q[MW_BIT];
            end
            WB:      reg_we = 1'b1;
            HALT:    halted = 1'b1;
            default: ;
        endcase
    end

    assign OUT         = out_q;
    assign state       = state_q;
    assign instr_count = cnt_q;

endmodule
